// File: rtl/inst_rom_loader.sv
// Instruction ROM whose contents are loaded at run time from a host byte stream.
// Optional `INST_ROM_CHECKSUM_EN adds checksum_o, a wrapping sum of the words written by the current load.
module inst_rom_loader #(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] NOP_WORD = 32'h00000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i,
    input  logic [31:0]       addr_i,
    output logic [31:0]       inst_o,
    output logic              cpu_hold_o,
    input  logic              ld_start_i,
    input  logic              ld_valid_i,
    input  logic [7:0]        ld_data_i,
    input  logic              ld_last_i,
    output logic              ld_ready_o,
    output logic [ADDR_W:0]   ld_words_o,
    output logic              ld_ovf_o
`ifdef INST_ROM_CHECKSUM_EN
    ,
    output logic [31:0]       checksum_o
`endif
);
    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t          state;
    logic [ADDR_W:0] ptr;
    logic [1:0]      byte_cnt;
    logic [31:0]     word_sr;
    logic [31:0]     mem [DEPTH];

    logic              accept;
    logic              wr_en;
    logic [31:0]       asm_word;
    logic [ADDR_W-1:0] rd_idx;
    logic              in_range;
    logic              addr_lsb_unused;

    always_comb begin
        accept   = ld_valid_i && ld_ready_o && !ld_start_i && (state == LOAD);
        wr_en    = accept && ((byte_cnt == 2'd3) || ld_last_i);
        // Left-justify the bytes collected so far; a short final word is zero-padded below.
        asm_word = {word_sr[23:0], ld_data_i} << {2'd3 - byte_cnt, 3'b000};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ptr        <= '0;
            byte_cnt   <= 2'd0;
            word_sr    <= 32'h0;
            ld_ovf_o   <= 1'b0;
            ld_ready_o <= 1'b0;
            cpu_hold_o <= 1'b1;
        end else if (ld_start_i) begin
            state      <= LOAD;
            ptr        <= '0;
            byte_cnt   <= 2'd0;
            word_sr    <= 32'h0;
            ld_ovf_o   <= 1'b0;
            ld_ready_o <= 1'b1;
            cpu_hold_o <= 1'b1;
        end else if (accept) begin
            if (wr_en) begin
                word_sr  <= 32'h0;
                byte_cnt <= 2'd0;
                ptr      <= ptr + 1'b1;
                // Filling the final location without a last marker means the image was too big.
                if (ld_last_i || (ptr == LAST_PTR)) begin
                    state      <= RUN;
                    ld_ready_o <= 1'b0;
                    cpu_hold_o <= 1'b0;
                    ld_ovf_o   <= !ld_last_i;
                end
            end else begin
                word_sr  <= {word_sr[23:0], ld_data_i};
                byte_cnt <= byte_cnt + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr[ADDR_W-1:0]] <= asm_word;
        end
    end

`ifdef INST_ROM_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum_o <= 32'h0;
        end else if (ld_start_i) begin
            checksum_o <= 32'h0;
        end else if (wr_en) begin
            checksum_o <= checksum_o + asm_word;
        end
    end
`endif

    assign ld_words_o = ptr;

    always_comb begin
        rd_idx          = addr_i[ADDR_W+1:2];
        in_range        = (addr_i[31:ADDR_W+2] == '0);
        addr_lsb_unused = ^addr_i[1:0];
        inst_o          = NOP_WORD;
        if (ce_i && (state == RUN) && in_range) begin
            inst_o = mem[rd_idx];
        end
    end
endmodule
